stream_pkt_fifo: RTL
====================

STREAM_PKT_FIFO -- requirements
Module: stream_pkt_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 4..64.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter KW, default 8, keep/byte-count sideband width.
REQ-004 clk  in  1  single clock; all state SHALL update on rising edge only.
REQ-005 arst  in  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-006 s_data  in  DW  upstream beat data.
REQ-007 s_valid  in  1  upstream beat valid.
REQ-008 s_last  in  1  final beat of upstream packet.
REQ-009 s_keep  in  KW  unsigned valid-byte count of the beat.
REQ-010 s_ready  out  1  block accepts beat this cycle.
REQ-011 m_data  out  DW  downstream beat data.
REQ-012 m_valid  out  1  downstream beat valid.
REQ-013 m_last  out  1  final beat of downstream packet.
REQ-014 m_keep  out  KW  byte count of downstream beat.
REQ-015 m_ready  in  1  downstream accepts beat.
REQ-016 len_valid  out  1  one-cycle pulse: packet length report valid.
REQ-017 len_bytes  out  16  sum of s_keep over the reported packet.
REQ-018 len_beats  out  8  beat count of the reported packet.
REQ-019 level  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-020 pkt_count  out  log2(DEPTH)+1  complete packets (last beat written) held in FIFO.

Function
REQ-021 Entry = {last, keep, data}; write on s_valid && s_ready; read on m_valid && m_ready; pointers wrap modulo DEPTH.
REQ-022 s_ready SHALL equal arst && (level != DEPTH); combinational; a read in the same cycle SHALL NOT make room for a write when full.
REQ-023 level: +1 write only, -1 read only, unchanged on simultaneous write+read or neither.
REQ-024 m_data/m_keep/m_last SHALL show the head entry combinationally; value undefined-but-stable when m_valid = 0 is not required; bench checks only when m_valid = 1.
REQ-025 Output FSM states IDLE, SEND; m_valid SHALL be 0 in IDLE.
REQ-026 IDLE -> SEND at next edge when pkt_count != 0 or level == DEPTH (cut-through fallback for packets longer than DEPTH).
REQ-027 SEND: m_valid = (level != 0); SEND -> IDLE at the edge where a beat with last = 1 is read; otherwise stay in SEND, including while level == 0.
REQ-028 Consequence: exactly one idle cycle (m_valid = 0) between consecutive output packets.
REQ-029 pkt_count: +1 on written beat with s_last = 1, -1 on read beat with last = 1, unchanged if both same cycle.
REQ-030 Length accumulators acc_bytes (16 b), acc_beats (8 b) SHALL add s_keep and 1 per written beat, saturating at 16'hFFFF and 8'hFF.
REQ-031 On written beat with s_last = 1: next cycle len_valid = 1, len_bytes/len_beats = totals including that beat; accumulators restart from 0 for the following beat in the same edge.
REQ-032 len_bytes/len_beats SHALL hold the last report until the next one; len_valid SHALL be 0 all other cycles.
REQ-033 Single-beat packet (s_last on first beat) SHALL report len_beats = 1, len_bytes = s_keep.
REQ-034 s_valid with s_ready = 0 SHALL change no state; s_keep/s_last of unaccepted beats SHALL NOT be accumulated.

Reset
REQ-035 While arst = 0 at a rising edge: pointers, level, pkt_count, accumulators, len_bytes, len_beats SHALL clear to 0; len_valid = 0; FSM = IDLE; stored entries discarded.
REQ-036 Outputs during/after reset cycle: s_ready = 0 while arst = 0, m_valid = 0, m_last = 0 until a new packet qualifies.
REQ-037 Reset mid-packet SHALL discard partial input and output packets; no len_valid pulse for the discarded packet.

Verification
REQ-038 Packet of 11 beats, keep = 16,16,8,4,12,16,4,8,16,16,16, m_ready = 1 -> m_valid stays 0 until cycle after beat 11 written; 11 beats out in order; len_valid once, len_bytes = 132, len_beats = 11.
REQ-039 DEPTH = 16, 20-beat packet, m_ready = 1 -> s_ready drops when level = 16; FSM enters SEND on full; all 20 beats out, m_last on beat 20.
REQ-040 Two 3-beat packets back-to-back, m_ready = 1 -> pkt_count reaches 2; exactly one m_valid = 0 cycle between packets; two len_valid pulses, len_beats = 3 each.
REQ-041 FIFO full, s_valid = 1, m_ready toggling 1/0 -> no write while level = 16; level and data order match model; no beat lost or duplicated.
REQ-042 arst = 0 for one cycle after 5 beats of a 10-beat packet -> level = 0, pkt_count = 0, m_valid = 0, no len_valid; next clean 2-beat packet keep = 3,5 -> len_bytes = 8, len_beats = 2.
REQ-043 300-beat packet keep = 255 each -> len_bytes = 16'hFFFF, len_beats = 8'hFF (saturated).

Source files
------------

// File: rtl/stream_pkt_fifo.sv
// Packet-aware stream FIFO: store-and-forward output with cut-through when full,
// plus per-packet byte/beat length reporting on the input side.
module stream_pkt_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16,
  parameter int KW    = 8
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_valid,
  input  logic                     s_last,
  input  logic [KW-1:0]            s_keep,
  output logic                     s_ready,
  output logic [DW-1:0]            m_data,
  output logic                     m_valid,
  output logic                     m_last,
  output logic [KW-1:0]            m_keep,
  input  logic                     m_ready,
  output logic                     len_valid,
  output logic [15:0]              len_bytes,
  output logic [7:0]               len_beats,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   pkt_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("stream_pkt_fifo: DEPTH must be a power of two in 4..64");
  end

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [0:0]     state;
  logic [15:0]    acc_bytes;
  logic [7:0]     acc_beats;
  logic           wr_en;
  logic           rd_en;
  logic           wr_last;
  logic           rd_last;
  logic [16:0]    bytes_sum;
  logic [8:0]     beats_sum;
  logic [15:0]    bytes_next;
  logic [7:0]     beats_next;

  // A read in the same cycle never frees a slot for a write when full.
  assign s_ready = arst && (level != FULL_LEVEL);
  assign wr_en   = s_valid && s_ready;

  assign head    = mem[rd_ptr];
  assign m_valid = arst && (state == SEND) && (level != '0);
  assign rd_en   = m_valid && m_ready;
  assign m_data  = head.data;
  assign m_keep  = head.keep;
  assign m_last  = m_valid && head.last;

  assign wr_last = wr_en && s_last;
  assign rd_last = rd_en && head.last;

  assign bytes_sum  = {1'b0, acc_bytes} + 17'(s_keep);
  assign beats_sum  = {1'b0, acc_beats} + 9'd1;
  assign bytes_next = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
  assign beats_next = beats_sum[8]  ? 8'hFF    : beats_sum[7:0];

  // NOTE: the storage array has no reset; clearing the pointers and level is
  // enough to discard its contents, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{last: s_last, keep: s_keep, data: s_data};
    end
  end

  // NOTE: every register here uses non-blocking assignment so all updates see
  // the pre-edge values of level, pkt_count and the accumulators.
  always_ff @(posedge clk) begin
    if (!arst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
      state     <= IDLE;
      acc_bytes <= '0;
      acc_beats <= '0;
      len_valid <= 1'b0;
      len_bytes <= '0;
      len_beats <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      case ({wr_last, rd_last})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase

      // Full FIFO without a complete packet starts cut-through forwarding.
      case (state)
        IDLE:    if (pkt_count != '0 || level == FULL_LEVEL) state <= SEND;
        SEND:    if (rd_last) state <= IDLE;
        default: state <= IDLE;
      endcase

      len_valid <= wr_last;
      if (wr_en) begin
        if (s_last) begin
          len_bytes <= bytes_next;
          len_beats <= beats_next;
          acc_bytes <= '0;
          acc_beats <= '0;
        end else begin
          acc_bytes <= bytes_next;
          acc_beats <= beats_next;
        end
      end
    end
  end

endmodule
